// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field widths, special encodings and accumulator state enum.
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;
endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: splits an FP32 word into sign, exponent and hidden-bit mantissa plus class flags.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       i_f,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W:0]   o_mant,
    output logic              o_zero,
    output logic              o_inf,
    output logic              o_nan
);
    logic w_frac_nz;
    logic w_exp_max;
    assign o_sign    = i_f[31];
    assign o_exp     = i_f[30:23];
    assign w_frac_nz = |i_f[22:0];
    assign w_exp_max = o_exp == EXP_W'(EXP_MAX);
    // subnormals flush to zero, so their fraction never reaches the datapath
    assign o_zero    = o_exp == '0;
    assign o_mant    = o_zero ? '0 : {1'b1, i_f[22:0]};
    assign o_inf     = w_exp_max && !w_frac_nz;
    assign o_nan     = w_exp_max && w_frac_nz;
endmodule

// File: rtl/fp_acc32.sv
// fp_acc32: multi-cycle FP32 accumulator (align/add/normalize/pack) with truncation rounding.
module fp_acc32
    import fp32_pkg::*;
#(
    parameter int MANT_EXT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] acc,
    output logic        busy,
    output logic        done
);
    localparam int W = FRAC_W + 2 + MANT_EXT;

    state_t       r_state;
    logic [31:0]  r_op, r_spec_val;
    logic         r_spec, r_sign, r_sub;
    logic [8:0]   r_exp;
    logic [W-1:0] r_mb, r_ms;

    logic              w_a_sign, w_a_zero, w_a_inf, w_a_nan;
    logic              w_b_sign, w_b_zero, w_b_inf, w_b_nan;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp, w_e_big, w_e_sml, w_diff;
    logic [FRAC_W:0]   w_a_mant, w_b_mant;
    logic [W-1:0]      w_a_ext, w_b_ext, w_m_big, w_m_sml, w_shifted, w_sum;
    logic              w_a_big, w_nan, w_inf, w_spec;
    logic [31:0]       w_inf_val, w_spec_val, w_packed;

    fp32_unpack u_acc (
        .i_f(acc), .o_sign(w_a_sign), .o_exp(w_a_exp), .o_mant(w_a_mant),
        .o_zero(w_a_zero), .o_inf(w_a_inf), .o_nan(w_a_nan)
    );
    fp32_unpack u_op (
        .i_f(r_op), .o_sign(w_b_sign), .o_exp(w_b_exp), .o_mant(w_b_mant),
        .o_zero(w_b_zero), .o_inf(w_b_inf), .o_nan(w_b_nan)
    );

    assign in_ready  = (r_state == IDLE) && !clear;
    assign busy      = r_state != IDLE;
    assign w_a_ext   = {1'b0, w_a_mant, {MANT_EXT{1'b0}}};
    assign w_b_ext   = {1'b0, w_b_mant, {MANT_EXT{1'b0}}};
    assign w_a_big   = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};
    assign w_e_big   = w_a_big ? w_a_exp : w_b_exp;
    assign w_e_sml   = w_a_big ? w_b_exp : w_a_exp;
    assign w_m_big   = w_a_big ? w_a_ext : w_b_ext;
    assign w_m_sml   = w_a_big ? w_b_ext : w_a_ext;
    assign w_diff    = w_e_big - w_e_sml;
    assign w_shifted = (w_diff >= 8'(W)) ? '0 : w_m_sml >> w_diff;
    assign w_nan     = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign));
    assign w_inf     = w_a_inf || w_b_inf;
    assign w_inf_val = w_a_inf ? (w_a_sign ? NINF : PINF) : (w_b_sign ? NINF : PINF);
    assign w_spec    = w_nan || w_inf || (w_a_zero && w_b_zero);
    assign w_spec_val = w_nan ? QNAN : w_inf ? w_inf_val : '0;
    assign w_sum     = r_sub ? r_mb - r_ms : r_mb + r_ms;
    // low MANT_EXT guard bits are dropped here, giving round-toward-zero
    assign w_packed  = r_spec ? r_spec_val :
                       (r_exp >= 9'(EXP_MAX)) ? {r_sign, 8'hFF, 23'h0} :
                       {r_sign, r_exp[7:0], r_mb[W-3:MANT_EXT]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            acc        <= '0;
            done       <= 1'b0;
            r_op       <= '0;
            r_spec_val <= '0;
            r_spec     <= 1'b0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= '0;
            r_mb       <= '0;
            r_ms       <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            acc     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op    <= in_data;
                    r_state <= ALIGN;
                end
                ALIGN: begin
                    r_sign     <= w_a_big ? w_a_sign : w_b_sign;
                    r_sub      <= w_a_sign != w_b_sign;
                    r_exp      <= {1'b0, w_e_big};
                    r_mb       <= w_m_big;
                    r_ms       <= w_shifted;
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_state    <= w_spec ? PACK : ADD;
                end
                ADD: begin
                    r_mb <= w_sum;
                    if (w_sum == '0) begin
                        r_spec     <= 1'b1;
                        r_spec_val <= '0;
                        r_state    <= PACK;
                    end else begin
                        r_state <= NORM;
                    end
                end
                NORM: if (r_mb[W-1]) begin
                    r_mb    <= r_mb >> 1;
                    r_exp   <= r_exp + 9'd1;
                    r_state <= PACK;
                end else if (r_mb[W-2]) begin
                    r_state <= PACK;
                end else if (r_exp <= 9'd1) begin
                    r_spec     <= 1'b1;
                    r_spec_val <= '0;
                    r_state    <= PACK;
                end else begin
                    r_mb  <= r_mb << 1;
                    r_exp <= r_exp - 9'd1;
                end
                PACK: begin
                    acc     <= w_packed;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_acc32.sv
// tb_fp_acc32: directed vectors against an exact-sum-then-truncate FP32 model, checked every cycle.
module tb_fp_acc32;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] acc;
    logic        busy, done;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_acc = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_next = '0;
    logic        pend = 1'b0;

    fp_acc32 dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .acc(acc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // exact integer sum of the two operands, then truncated to 24 significant bits
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e0, lead, e;
        longint sa, sb, s;
        logic [63:0] m;
        logic sg;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0) return (eb == 0) ? 32'h0 : b;
        if (eb == 0) return a;
        if (ea - eb > 40) return a;
        if (eb - ea > 40) return b;
        e0 = (ea < eb) ? ea : eb;
        sa = longint'({1'b1, a[22:0]}) <<< (ea - e0);
        sb = longint'({1'b1, b[22:0]}) <<< (eb - e0);
        if (a[31]) sa = -sa;
        if (b[31]) sb = -sb;
        s = sa + sb;
        if (s == 0) return 32'h0;
        sg = s < 0;
        if (sg) s = -s;
        lead = 0;
        for (int i = 0; i < 64; i++) if (s[i]) lead = i;
        e = e0 + lead - 23;
        if (e >= 255) return {sg, 8'hFF, 23'h0};
        if (e < 1) return 32'h0;
        m = (lead >= 23) ? 64'(s >> (lead - 23)) : 64'(s << (23 - lead));
        return {sg, 8'(e), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // predict the coming edge from current inputs, then compare outputs after it
    task automatic step();
        if (reset || clear) begin
            m_acc = '0;
            pend  = 1'b0;
        end else if (in_valid && !pend) begin
            pend   = 1'b1;
            n_acc++;
            m_next = model_add(m_acc, in_data);
        end
        @(negedge clk);
        if (done) begin
            check("done_pending", 32'(pend), 32'd1);
            check("acc_on_done", acc, m_next);
            m_acc = m_next;
            pend  = 1'b0;
        end else begin
            check("acc_hold", acc, m_acc);
        end
        check("busy", 32'(busy), 32'(pend));
        check("in_ready", 32'(in_ready), 32'(!pend && !clear));
    endtask

    task automatic run_op(input logic [31:0] d, input logic [31:0] want_acc, input int want_lat);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        check("latency", 32'(n), 32'(want_lat));
        check("result", acc, want_acc);
    endtask

    initial begin
        logic [31:0] seq [3];
        int n, nd;
        seq = '{32'h3F800000, 32'h40000000, 32'h40400000};

        check("model_1p2", model_add(32'h3F800000, 32'h40000000), 32'h40400000);
        check("model_1m075", model_add(32'h3F800000, 32'hBF400000), 32'h3E800000);
        check("model_ovf", model_add(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F800000);
        check("model_infnan", model_add(32'h7F800000, 32'hFF800000), 32'h7FC00000);
        check("model_cancel", model_add(32'h40400000, 32'hC0400000), 32'h00000000);

        step();
        step();
        check("reset_acc", acc, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        run_op(32'h3F800000, 32'h3F800000, 4);
        run_op(32'h40000000, 32'h40400000, 4);
        run_op(32'hC0400000, 32'h00000000, 3);
        run_op(32'h3F800000, 32'h3F800000, 4);
        run_op(32'hBF400000, 32'h3E800000, 6);

        clear = 1'b1;
        step();
        clear = 1'b0;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 4);
        run_op(32'h7F7FFFFF, 32'h7F800000, 4);
        run_op(32'hFF800000, 32'h7FC00000, 2);

        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        step();
        in_valid = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        check("ready_after_clear", 32'(in_ready), 32'd1);
        check("acc_after_clear", acc, 32'h0);
        check("no_done_on_clear", 32'(done), 32'd0);
        repeat (6) step();

        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        n_acc = 0;
        nd = 0;
        n = 0;
        while (nd < 3 && n < 60) begin
            step();
            n++;
            if (done) begin
                check("hold_acc", acc, seq[nd]);
                nd++;
            end
        end
        in_valid = 1'b0;
        check("hold_dones", 32'(nd), 32'd3);
        check("hold_accepts", 32'(n_acc), 32'd3);
        check("hold_cycles", 32'(n), 32'd15);
        repeat (4) step();
        check("final_acc", acc, 32'h40400000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
